// File: rtl/m_memarb_if.sv
// Bundles the two requester ports and the single-port memory bus around m_memarb.
// slave = arbiter side; master = processor core plus memory side.
interface m_memarb_if #(
    parameter int P_AW = 12,
    parameter int P_DW = 32
);
    logic            w_req0;
    logic            w_req1;
    logic            w_we0;
    logic            w_we1;
    logic [P_AW-1:0] w_addr0;
    logic [P_AW-1:0] w_addr1;
    logic [P_DW-1:0] w_din0;
    logic [P_DW-1:0] w_din1;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_vld0;
    logic            w_vld1;
    logic [P_DW-1:0] w_dout0;
    logic [P_DW-1:0] w_dout1;
    logic [P_AW-1:0] w_maddr;
    logic            w_mwe;
    logic [P_DW-1:0] w_mdin;
    logic [P_DW-1:0] w_mdout;
    logic            w_busy;

    modport slave (
        input  w_req0, w_req1, w_we0, w_we1, w_addr0, w_addr1, w_din0, w_din1, w_mdout,
        output w_gnt0, w_gnt1, w_vld0, w_vld1, w_dout0, w_dout1,
               w_maddr, w_mwe, w_mdin, w_busy
    );

    modport master (
        output w_req0, w_req1, w_we0, w_we1, w_addr0, w_addr1, w_din0, w_din1, w_mdout,
        input  w_gnt0, w_gnt1, w_vld0, w_vld1, w_dout0, w_dout1,
               w_maddr, w_mwe, w_mdin, w_busy
    );
endinterface

// File: rtl/m_memarb.sv
// Two-port fetch/data arbiter for one single-port memory; `MEMARB_RR_EN selects round-robin (default: port 1 priority).
// Latency: combinational grant, access P_WAIT+1 cycles, vld/read data P_WAIT+2 cycles after grant.
// Backpressure: a request is held until its grant pulse; next grant overlaps the last access cycle.
module m_memarb #(
    parameter int P_AW   = 12,
    parameter int P_DW   = 32,
    parameter int P_WAIT = 0
) (
    input  logic      w_clk,
    input  logic      w_rst,
    m_memarb_if.slave bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [2:0] WAIT3 = 3'(P_WAIT);

    state_t          state_q, state_d;
    logic [2:0]      wcnt_q, wcnt_d;
    logic            last_q, last_d;
    logic            own_q, own_d;
    logic            we_q, we_d;
    logic [P_AW-1:0] addr_q, addr_d;
    logic [P_DW-1:0] din_q, din_d;
    logic [P_DW-1:0] dout0_q, dout0_d;
    logic [P_DW-1:0] dout1_q, dout1_d;
    logic            vld0_q, vld0_d;
    logic            vld1_q, vld1_d;

    logic            decide;
    logic            last_cyc;
    logic            gnt0_c, gnt1_c;
    logic            busy_c;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q <= IDLE;
            wcnt_q  <= 3'd0;
            last_q  <= 1'b1;
            own_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            dout0_q <= '0;
            dout1_q <= '0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            last_q  <= last_d;
            own_q   <= own_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
            vld0_q  <= vld0_d;
            vld1_q  <= vld1_d;
        end
    end

    always_comb begin
        decide   = (state_q == IDLE) || (wcnt_q == 3'd0);
        last_cyc = (state_q == ACCESS) && (wcnt_q == 3'd0);

        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (decide && !w_rst) begin
            if (bus.w_req0 && bus.w_req1) begin
`ifdef MEMARB_RR_EN
                gnt0_c = last_q;
                gnt1_c = !last_q;
`else
                gnt1_c = 1'b1;
`endif
            end else begin
                gnt0_c = bus.w_req0;
                gnt1_c = bus.w_req1;
            end
        end

        state_d = state_q;
        wcnt_d  = wcnt_q;
        last_d  = last_q;
        own_d   = own_q;
        we_d    = we_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        vld0_d  = 1'b0;
        vld1_d  = 1'b0;

        if (state_q == ACCESS && wcnt_q != 3'd0) begin
            wcnt_d = wcnt_q - 3'd1;
        end

        // Completion of the running access; writes leave the owner's read data untouched.
        if (last_cyc) begin
            if (own_q) begin
                vld1_d = 1'b1;
                if (!we_q) dout1_d = bus.w_mdout;
            end else begin
                vld0_d = 1'b1;
                if (!we_q) dout0_d = bus.w_mdout;
            end
        end

        if (decide) begin
            if (gnt0_c || gnt1_c) begin
                state_d = ACCESS;
                wcnt_d  = WAIT3;
                own_d   = gnt1_c;
                last_d  = gnt1_c;
                we_d    = gnt1_c ? bus.w_we1   : bus.w_we0;
                addr_d  = gnt1_c ? bus.w_addr1 : bus.w_addr0;
                din_d   = gnt1_c ? bus.w_din1  : bus.w_din0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // The write strobe is confined to the final access cycle and suppressed under reset.
    always_comb begin
        busy_c      = (state_q == ACCESS) && !w_rst;
        bus.w_busy  = busy_c;
        bus.w_maddr = '0;
        bus.w_mdin  = '0;
        bus.w_mwe   = 1'b0;
        if (busy_c) begin
            bus.w_maddr = addr_q;
            bus.w_mdin  = din_q;
            bus.w_mwe   = we_q && (wcnt_q == 3'd0);
        end
        bus.w_gnt0  = gnt0_c;
        bus.w_gnt1  = gnt1_c;
        bus.w_vld0  = vld0_q;
        bus.w_vld1  = vld1_q;
        bus.w_dout0 = dout0_q;
        bus.w_dout1 = dout1_q;
    end
endmodule

// File: tb/tb_m_memarb.sv
// Scoreboard bench for m_memarb: a request-level model predicts grants, writes and completions,
// and a free-running monitor compares whatever the arbiter presents against those predictions.
module tb_m_memarb;
    localparam int TB_WAIT = 2;
    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct {
        int          port;
        int          cyc;
        logic [11:0] addr;
        logic [31:0] dat;
        logic [31:0] old;
    } ev_t;

    typedef struct {
        int cyc;
        bit chk_busy;
        bit busy;
        bit zero;
    } cy_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    m_memarb_if #(.P_AW(AW), .P_DW(DW)) bus();

    m_memarb #(.P_AW(AW), .P_DW(DW), .P_WAIT(TB_WAIT)) dut (
        .w_clk(clk),
        .w_rst(rst),
        .bus  (bus)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'(i) * 32'h111;
    endfunction

    // Behavioural single-port memory: combinational read, write on the clock edge.
    logic [31:0] mem [4096];
    bit          mem_ready = 1'b0;
    assign bus.w_mdout = mem[bus.w_maddr];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (bus.w_mwe) begin
            mem[bus.w_maddr] <= bus.w_mdin;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    ev_t gnt_q[$];
    ev_t cmp_q[$];
    ev_t wr_q[$];
    cy_t cy_q[$];
    int  obs_q[$];

    logic [31:0] shadow [4096];
    logic [31:0] mdl [2];
    int          rem = 0;
    int          last = 1;
    int          g_win = -1;
    bit          zero_next = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: runs every cycle, mid-cycle, independent of the stimulus.
    initial begin
        ev_t e;
        cy_t c;
        int  p;
        forever begin
            @(negedge clk);
            if (cy_q.size() > 0 && cy_q[0].cyc == cyc) begin
                c = cy_q.pop_front();
                if (c.chk_busy) chk("busy", 64'(bus.w_busy), 64'(c.busy));
                if (c.zero) begin
                    chk("rst_maddr", 64'(bus.w_maddr), 64'd0);
                    chk("rst_mdin",  64'(bus.w_mdin),  64'd0);
                    chk("rst_mwe",   64'(bus.w_mwe),   64'd0);
                    chk("rst_vld",   64'({bus.w_vld1, bus.w_vld0}), 64'd0);
                    chk("rst_dout0", 64'(bus.w_dout0), 64'd0);
                    chk("rst_dout1", 64'(bus.w_dout1), 64'd0);
                    chk("rst_gnt",   64'({bus.w_gnt1, bus.w_gnt0}), 64'd0);
                end
            end

            chk("gnt_exclusive", 64'(bus.w_gnt0 & bus.w_gnt1), 64'd0);
            while (gnt_q.size() > 0 && gnt_q[0].cyc < cyc) begin
                e = gnt_q.pop_front();
                chk("gnt_missing_cycle", 64'(cyc), 64'(e.cyc));
            end
            if (bus.w_gnt0 || bus.w_gnt1) begin
                p = bus.w_gnt1 ? 1 : 0;
                obs_q.push_back(p);
                if (gnt_q.size() == 0) begin
                    chk("gnt_unexpected_port", 64'(p), 64'd2);
                end else begin
                    e = gnt_q.pop_front();
                    chk("gnt_port",  64'(p),   64'(e.port));
                    chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
                end
            end

            chk("vld_exclusive", 64'(bus.w_vld0 & bus.w_vld1), 64'd0);
            while (cmp_q.size() > 0 && cmp_q[0].cyc < cyc) begin
                e = cmp_q.pop_front();
                chk("vld_missing_cycle", 64'(cyc), 64'(e.cyc));
            end
            if (bus.w_vld0 || bus.w_vld1) begin
                p = bus.w_vld1 ? 1 : 0;
                if (cmp_q.size() == 0) begin
                    chk("vld_unexpected_port", 64'(p), 64'd2);
                end else begin
                    e = cmp_q.pop_front();
                    chk("vld_port",  64'(p),   64'(e.port));
                    chk("vld_cycle", 64'(cyc), 64'(e.cyc));
                    chk("dout", 64'(p ? bus.w_dout1 : bus.w_dout0), 64'(e.dat));
                end
            end

            while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                e = wr_q.pop_front();
                chk("mwe_missing_cycle", 64'(cyc), 64'(e.cyc));
            end
            if (bus.w_mwe) begin
                if (wr_q.size() == 0) begin
                    chk("mwe_unexpected_addr", 64'(bus.w_maddr), 64'hFFFF_FFFF);
                end else begin
                    e = wr_q.pop_front();
                    chk("mwe_addr",  64'(bus.w_maddr), 64'(e.addr));
                    chk("mwe_data",  64'(bus.w_mdin),  64'(e.dat));
                    chk("mwe_cycle", 64'(cyc),         64'(e.cyc));
                end
            end
        end
    end

    // One clock of stimulus plus the reference model's prediction for that clock.
    task automatic step(input bit rs,
                        input bit r0, input bit we0, input logic [11:0] a0, input logic [31:0] d0,
                        input bit r1, input bit we1, input logic [11:0] a1, input logic [31:0] d1);
        ev_t         e;
        cy_t         c;
        bit          dec;
        bit          w;
        logic [11:0] a;
        logic [31:0] d;
        e = '{default: 0};
        rst         = rs;
        bus.w_req0  = r0;
        bus.w_we0   = we0;
        bus.w_addr0 = a0;
        bus.w_din0  = d0;
        bus.w_req1  = r1;
        bus.w_we1   = we1;
        bus.w_addr1 = a1;
        bus.w_din1  = d1;
        g_win = -1;
        if (rs) begin
            // The aborted access never commits and never completes.
            while (wr_q.size() > 0 && wr_q[$].cyc >= cyc) begin
                e = wr_q.pop_back();
                shadow[e.addr] = e.old;
            end
            while (cmp_q.size() > 0 && cmp_q[$].cyc > cyc) void'(cmp_q.pop_back());
            rem = 0;
            last = 1;
            mdl[0] = '0;
            mdl[1] = '0;
            c = '{cyc, 1'b0, 1'b0, 1'b0};
            cy_q.push_back(c);
            zero_next = 1'b1;
        end else begin
            c = '{cyc, 1'b1, (rem > 0), zero_next};
            cy_q.push_back(c);
            zero_next = 1'b0;
            dec = (rem <= 1);
            if (dec && r0 && r1) begin
`ifdef MEMARB_RR_EN
                g_win = (last == 1) ? 0 : 1;
`else
                g_win = 1;
`endif
            end else if (dec && r0) begin
                g_win = 0;
            end else if (dec && r1) begin
                g_win = 1;
            end
            if (g_win >= 0) begin
                w = (g_win == 1) ? we1 : we0;
                a = (g_win == 1) ? a1 : a0;
                d = (g_win == 1) ? d1 : d0;
                e.port = g_win;
                e.cyc  = cyc;
                gnt_q.push_back(e);
                if (w) begin
                    e.addr = a;
                    e.dat  = d;
                    e.old  = shadow[a];
                    e.cyc  = cyc + 1 + TB_WAIT;
                    wr_q.push_back(e);
                    shadow[a] = d;
                end else begin
                    mdl[g_win] = shadow[a];
                end
                e.cyc = cyc + 2 + TB_WAIT;
                e.dat = mdl[g_win];
                cmp_q.push_back(e);
                rem  = TB_WAIT + 1;
                last = g_win;
            end else if (dec) begin
                rem = 0;
            end else begin
                rem = rem - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0);
    endtask

    initial begin
        bit          h [2];
        bit          hwe [2];
        logic [11:0] ha [2];
        logic [31:0] hd [2];
        int          exp_o [6];
        int          ngr;
        int          dens;
        logic [31:0] pre5;

        bus.w_req0 = 1'b0; bus.w_we0 = 1'b0; bus.w_addr0 = '0; bus.w_din0 = '0;
        bus.w_req1 = 1'b0; bus.w_we1 = 1'b0; bus.w_addr1 = '0; bus.w_din1 = '0;
        for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);
        mdl[0] = '0;
        mdl[1] = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0);
        idle(2);

        // Single read of address 3 from the fetch port.
        step(1'b0, 1'b1, 1'b0, 12'd3, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0);
        idle(5);

        // Data port writes 0x55 to 32, then reads it back.
        step(1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 1'b1, 1'b1, 12'd32, 32'h55);
        idle(4);
        step(1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 12'd32, 32'd0);
        idle(5);

        // Both ports request continuously until six grants are issued.
`ifdef MEMARB_RR_EN
        exp_o = '{0, 1, 0, 1, 0, 1};
`else
        exp_o = '{1, 1, 1, 1, 1, 1};
`endif
        obs_q.delete();
        ngr = 0;
        for (int i = 0; i < 60 && ngr < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 12'd1, 32'd0, 1'b1, 1'b0, 12'd2, 32'd0);
            if (g_win >= 0) ngr++;
        end
        chk("conflict_count", 64'(obs_q.size()), 64'd6);
        for (int k = 0; k < 6 && k < obs_q.size(); k++) chk("conflict_order", 64'(obs_q[k]), 64'(exp_o[k]));
        idle(6);

        // Fetch port request raised during a data access and dropped before the decision cycle.
        obs_q.delete();
        step(1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 12'd7, 32'd0);
        step(1'b0, 1'b1, 1'b0, 12'd9, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 12'd9, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0);
        idle(5);
        chk("withdraw_grants", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() > 0) chk("withdraw_port", 64'(obs_q[0]), 64'd1);

        // Randomised traffic with varying request density and occasional withdrawal.
        h = '{0, 0};
        hwe = '{0, 0};
        ha = '{12'd0, 12'd0};
        hd = '{32'd0, 32'd0};
        for (int i = 0; i < 1500; i++) begin
            dens = ((i / 250) % 3 == 0) ? 15 : (((i / 250) % 3 == 1) ? 50 : 90);
            for (int p = 0; p < 2; p++) begin
                if (h[p] && $urandom_range(15) == 0) begin
                    h[p] = 1'b0;
                end else if (!h[p] && $urandom_range(99) < dens) begin
                    h[p]   = 1'b1;
                    hwe[p] = 1'($urandom_range(1));
                    ha[p]  = 12'($urandom_range(15));
                    hd[p]  = $urandom;
                end
            end
            step(1'b0, h[0], hwe[0], ha[0], hd[0], h[1], hwe[1], ha[1], hd[1]);
            if (g_win >= 0) h[g_win] = 1'b0;
        end
        idle(6);

        // Reset in the second access cycle of a write of 0xAA to address 5.
        pre5 = mem[5];
        step(1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 1'b1, 1'b1, 12'd5, 32'hAA);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 12'd4, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0);
        idle(8);
        chk("mem5_kept", 64'(mem[5]), 64'(pre5));

        chk("gnt_q_left", 64'(gnt_q.size()), 64'd0);
        chk("cmp_q_left", 64'(cmp_q.size()), 64'd0);
        chk("wr_q_left",  64'(wr_q.size()),  64'd0);
        for (int i = 0; i < 40; i++) chk("mem_contents", 64'(mem[i]), 64'(shadow[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/m_memarb.md
# m_memarb

Two-port arbiter and access sequencer that shares one single-port 4K-word `m_amemory` between the processor's instruction-fetch port (port 0) and data load/store port (port 1). It sits between the processor core and the memory and drives the memory's address, write-enable and write-data inputs. It grants one access at a time, inserts configurable wait states, and registers read data back to the winning requester.

## Interface
- `P_AW`, default 12, address width; matches the `m_amemory` word address.
- `P_DW`, default 32, data width.
- `P_WAIT`, default 0, extra wait cycles per access; legal range 0–7.

Ports:
- `w_clk` in 1: single clock; all state updates on its rising edge.
- `w_rst` in 1: synchronous, active-high reset.
- `w_req0`, `w_req1` in 1: access request from port 0 (fetch) and port 1 (data).
- `w_we0`, `w_we1` in 1: 1 = write, 0 = read.
- `w_addr0`, `w_addr1` in `P_AW`: word address.
- `w_din0`, `w_din1` in `P_DW`: write data.
- `w_gnt0`, `w_gnt1` out 1: request accepted this cycle.
- `w_vld0`, `w_vld1` out 1: one-cycle completion pulse.
- `w_dout0`, `w_dout1` out `P_DW`: last read data returned to that port.
- `w_maddr` out `P_AW`, `w_mwe` out 1, `w_mdin` out `P_DW`: drive the memory.
- `w_mdout` in `P_DW`: memory read data.
- `w_busy` out 1: an access is in progress (state ACCESS).

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: a latched access runs for `P_WAIT`+1 cycles; a down-counter `r_wcnt` (3 bits) is loaded with `P_WAIT`.
- Decision cycle: any IDLE cycle, or the last ACCESS cycle (`r_wcnt`==0).
- In a decision cycle with at least one request:
  - One winner is chosen combinationally and its `w_gntN` is asserted that cycle.
  - At the next edge the arbiter latches owner, address, we and din, loads `r_wcnt`=`P_WAIT`, and enters or stays in ACCESS.
  - With no request, the arbiter goes to or stays in IDLE.
- Requester rule: hold `w_reqN`, `w_weN`, `w_addrN` and `w_dinN` stable until the cycle `w_gntN`=1. Deasserting a request before grant withdraws it. A request still high after the grant cycle is a new access.
- During ACCESS, `w_maddr` and `w_mdin` come from the latched registers.
- `w_mwe` is asserted only in the last ACCESS cycle, so exactly one write commits per write access.
- Outside ACCESS: `w_maddr`=0, `w_mdin`=0, `w_mwe`=0.
- At the edge ending the last ACCESS cycle:
  - A read captures `w_mdout` into `r_doutN` of the owner.
  - `w_vldN` of the owner is high for the following cycle, for reads and writes alike.
  - `w_doutN` is unchanged by writes and holds its value until that port's next read.
- Conflict (both requests in a decision cycle): the winner is set by the Configuration section.
- `r_last` records the last granted port.

## Timing
- Reset values:
  - state IDLE, `r_wcnt`=0, `r_last`=1.
  - `w_gnt0`/`w_gnt1`=0 during the reset cycle, `w_vld0`/`w_vld1`=0, `w_dout0`/`w_dout1`=0.
  - `w_busy`=0, `w_mwe`=0, `w_maddr`=0, `w_mdin`=0.
- Latency:
  - Grant at cycle t, memory access in cycles t+1 … t+1+`P_WAIT`.
  - `w_vld` in cycle t+2+`P_WAIT`.
  - Read-to-data latency after grant is therefore `P_WAIT`+2 cycles.
- Throughput: back-to-back accesses, one every `P_WAIT`+1 cycles. The next grant overlaps the last ACCESS cycle, so there is no idle bubble.
- `w_gnt` is a combinational, single-cycle pulse. Both grants are never high together.
- Reset asserted mid-ACCESS:
  - Next cycle is IDLE.
  - `w_mwe` is forced 0 during the reset cycle, so a pending write never commits.
  - The aborted access is not replayed and produces no `w_vld`.
- `P_WAIT`=0: ACCESS lasts one cycle, and every ACCESS cycle is a decision cycle.

## Configuration
- Macro `MEMARB_RR_EN`.
- Defined: round-robin arbitration. On conflict, the port ≠ `r_last` wins. After reset the first conflict goes to port 0.
- Undefined: fixed priority. Port 1 (data) always wins a conflict, and port 0 can starve under continuous port-1 requests.
- Non-conflict behaviour is identical in both builds.

## Test plan
- **Single read:** `P_WAIT`=0, memory[3]=0x333, port 0 reads addr 3 → `w_gnt0` at t, `w_maddr`=3 at t+1, `w_vld0` at t+2, `w_dout0`=0x333.
- **Write then read:** port 1 writes 0x55 to addr 32, then reads addr 32 → exactly one cycle with `w_mwe`=1 and `w_maddr`=32, then `w_dout1`=0x55. `w_dout0` stays unchanged.
- **Wait states:** `P_WAIT`=2, read → `w_busy` high 3 cycles, `w_vld` 4 cycles after grant. Under continuous requests, grants occur every 3 cycles.
- **Conflict, both builds:** both ports request continuously for 6 grants.
  - With `MEMARB_RR_EN`: grant order 0,1,0,1,0,1.
  - Without it: 1,1,1,1,1,1 and `w_gnt0` never asserts.
- **Reset mid-write:** `P_WAIT`=3, assert `w_rst` in the 2nd ACCESS cycle of a write of 0xAA to addr 5 → memory[5] unchanged, no `w_vld`, all outputs at reset values next cycle.
- **Request withdrawal:** port 0 raises a request during port 1's ACCESS, then drops it before the decision cycle → no `w_gnt0`, FSM returns to IDLE.
